// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. It owns the PC, addresses the ROM and
//            buffers {instr, pc} pairs that decode takes over valid/ready.
// Option   : FETCH_BOUNDS_CHECK_EN adds a sticky out-of-range fault output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int N     = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  output logic          d_valid,
  input  logic          d_ready,
  output logic [31:0]   d_instr,
  output logic [N-1:0]  d_pc,
  output logic          halted
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic          fault
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            halted_q, halted_d;
  logic [31:0]     instr_q [DEPTH];
  logic [N-1:0]    epc_q   [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_pop_hs;
  logic            w_room;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic            fault_q, fault_d;
  logic            w_oob;
  assign w_oob = (pc_q[N-1:AW+2] != '0);
  assign fault = fault_q;
`endif

  assign imem_addr = pc_q[AW+1:2];
  assign d_valid   = (count_q != '0);
  assign d_instr   = d_valid ? instr_q[head_q] : 32'h0;
  assign d_pc      = d_valid ? epc_q[head_q]   : '0;
  assign halted    = halted_q;

  assign w_pop_hs  = d_valid && d_ready;
  assign w_room    = (count_q < C_DEPTH) || w_pop_hs;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    w_push  = 1'b0;
    w_pop   = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif

    if (br_taken) begin
      // Redirect flushes everything, including a pop handshake this cycle.
      pc_d    = br_target & ~N'(3);
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      if (state_q == S_HALT) state_d = S_RUN;
    end else begin
      w_pop = w_pop_hs;
      case (state_q)
        S_IDLE: if (en) state_d = S_RUN;
        S_RUN: begin
          if (en && w_room) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (w_oob) begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end else
`endif
            if (imem_q == 32'h0) state_d = S_HALT;
            else                 w_push  = 1'b1;
          end
        end
        default: ;
      endcase

      if (w_push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + N'(4);
      end
      if (w_pop) head_d = head_q + 1'b1;

      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    halted_d = (state_d == S_HALT) && (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        epc_q[i]   <= '0;
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      halted_q <= halted_d;
      if (w_push) begin
        instr_q[tail_q] <= imem_q;
        epc_q[tail_q]   <= pc_q;
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit (honours
//            FETCH_BOUNDS_CHECK_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          br_taken;
  logic [N-1:0]  br_target;
  logic          d_valid;
  logic          d_ready;
  logic [31:0]   d_instr;
  logic [N-1:0]  d_pc;
  logic          halted;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic          fault;
`endif

  logic [31:0] rom [64];
  logic [31:0] exp_instr [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  fetch_unit #(.N(N), .AW(AW), .DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .imem_addr (imem_addr),
    .imem_q    (imem_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .halted    (halted)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .fault     (fault)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en        = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    d_ready   = 1'b0;
    reset_n   = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    en = 1'b0; br_taken = 1'b0; br_target = '0; d_ready = 1'b0;
    reset_n = 1'b0;
    #7;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", d_valid); end
    checks++; if (d_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", d_instr); end
    checks++; if (d_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", d_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    d_ready = 1'b1;
    en      = 1'b1;
    step();  // IDLE -> RUN, no push yet
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL seq_idle_valid got %0b want 0", d_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d_valid !== 1'b1 || d_instr !== exp_instr[i] || d_pc !== 64'(4 * i)) begin
        errors++;
        $display("FAIL seq_word%0d got v=%0b %h @%h want v=1 %h @%h", i, d_valid, d_instr, d_pc, exp_instr[i], 64'(4 * i));
      end
      step();
    end
    checks++; if (d_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL seq_halt got v=%0b h=%0b want v=0 h=1", d_valid, halted); end
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL seq_pc_hold got addr %0d want 4", imem_addr); end
  endtask

  task automatic test_halt_escape();
    br_taken  = 1'b1;
    br_target = 64'h8;
    d_ready   = 1'b1;
    step();
    br_taken = 1'b0;
    checks++; if (halted !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL esc_state got h=%0b v=%0b want h=0 v=0", halted, d_valid); end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL esc_addr got %0d want 2", imem_addr); end
    step();
    checks++; if (d_valid !== 1'b1 || d_instr !== 32'hf8000203 || d_pc !== 64'h8) begin errors++; $display("FAIL esc_word got v=%0b %h @%h want v=1 f8000203 @8", d_valid, d_instr, d_pc); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    en      = 1'b1;
    d_ready = 1'b0;
    step();
    repeat (5) step();
    checks++; if (d_valid !== 1'b1 || d_pc !== 64'h0 || d_instr !== 32'hf8000001) begin errors++; $display("FAIL bp_head got v=%0b %h @%h want v=1 f8000001 @0", d_valid, d_instr, d_pc); end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL bp_pc_stop got addr %0d want 2", imem_addr); end
    d_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (d_valid !== 1'b1 || d_instr !== exp_instr[i] || d_pc !== 64'(4 * i)) begin
        errors++;
        $display("FAIL bp_drain%0d got v=%0b %h @%h want v=1 %h @%h", i, d_valid, d_instr, d_pc, exp_instr[i], 64'(4 * i));
      end
    end
    step();
    checks++; if (d_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL bp_halt got v=%0b h=%0b want v=0 h=1", d_valid, halted); end
  endtask

  task automatic test_redirect();
    do_reset();
    en      = 1'b1;
    d_ready = 1'b0;
    repeat (3) step();
    checks++; if (d_valid !== 1'b1 || imem_addr !== 6'd2) begin errors++; $display("FAIL br_pre got v=%0b addr %0d want v=1 addr 2", d_valid, imem_addr); end
    br_taken  = 1'b1;
    br_target = 64'h1F;
    d_ready   = 1'b1;
    step();
    br_taken = 1'b0;
    d_ready  = 1'b0;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL br_flush got v=%0b want 0", d_valid); end
    checks++; if (imem_addr !== 6'd7) begin errors++; $display("FAIL br_addr got %0d want 7", imem_addr); end
    step();
    checks++; if (d_valid !== 1'b1 || d_instr !== 32'h00700013 || d_pc !== 64'h1C) begin errors++; $display("FAIL br_target_word got v=%0b %h @%h want v=1 00700013 @1c", d_valid, d_instr, d_pc); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en      = 1'b1;
    d_ready = 1'b0;
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (d_valid !== 1'b0 || d_pc !== 64'h0 || d_instr !== 32'h0) begin errors++; $display("FAIL mid_reset got v=%0b %h @%h want v=0 0 @0", d_valid, d_instr, d_pc); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL mid_reset_addr got %0d want 0", imem_addr); end
    reset_n = 1'b1;
    step();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mid_restart_idle got v=%0b want 0", d_valid); end
    step();
    checks++; if (d_valid !== 1'b1 || d_instr !== 32'hf8000001 || d_pc !== 64'h0) begin errors++; $display("FAIL mid_restart got v=%0b %h @%h want v=1 f8000001 @0", d_valid, d_instr, d_pc); end
  endtask

  task automatic test_bounds();
    do_reset();
    en      = 1'b1;
    d_ready = 1'b0;
    step();
    br_taken  = 1'b1;
    br_target = 64'h100;
    step();
    br_taken = 1'b0;
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || d_valid !== 1'b0) begin errors++; $display("FAIL oob_fault got f=%0b h=%0b v=%0b want f=1 h=1 v=0", fault, halted, d_valid); end
    br_taken  = 1'b1;
    br_target = 64'h0;
    step();
    br_taken = 1'b0;
    step();
    checks++; if (fault !== 1'b1 || d_valid !== 1'b1 || d_pc !== 64'h0) begin errors++; $display("FAIL oob_sticky got f=%0b v=%0b @%h want f=1 v=1 @0", fault, d_valid, d_pc); end
`else
    checks++; if (d_valid !== 1'b1 || d_instr !== 32'hf8000001 || d_pc !== 64'h100) begin errors++; $display("FAIL wrap_word got v=%0b %h @%h want v=1 f8000001 @100", d_valid, d_instr, d_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL wrap_halted got %0b want 0", halted); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'hf8000001;
    rom[1] = 32'hf8008002;
    rom[2] = 32'hf8000203;
    rom[3] = 32'h8b050083;
    rom[5] = 32'h11111111;
    rom[6] = 32'h22222222;
    rom[7] = 32'h00700013;
    for (int i = 0; i < 4; i++) exp_instr[i] = rom[i];

    test_reset();
    test_sequential();
    test_halt_escape();
    test_back_pressure();
    test_redirect();
    test_reset_mid_run();
    test_bounds();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
